pid_pipe: RTL and testbench
===========================

PID_PIPE -- requirements
Module: pid_pipe

Interface
REQ-001 Parameter ERR_W, default 12, signed raw error width.
REQ-002 Parameter SAT_W, default 10, saturated error width.
REQ-003 Parameter FRWRD_W, default 10, unsigned forward-speed width; speed outputs are FRWRD_W+1 bits.
REQ-004 Parameter P_COEFF, default 16, unsigned proportional gain (6 bits).
REQ-005 Parameter D_COEFF, default 7, unsigned derivative gain (5 bits).
REQ-006 Parameter D_DEPTH, default 3, range 1..8, number of err_vld samples back used for the derivative.
REQ-007 Parameter I_SHIFT, default 6, right shift from integrator to I term.
REQ-008 clk  input  1  clock, rising edge.
REQ-009 rst_n  input  1  reset, asynchronous, active-low.
REQ-010 moving  input  1  high enables control; low clears integrator and forces zero speeds.
REQ-011 err_vld  input  1  single-cycle qualifier for error.
REQ-012 error  input  ERR_W  signed heading error.
REQ-013 frwrd  input  FRWRD_W  unsigned forward speed, sampled with err_vld.
REQ-014 lft_spd  output  FRWRD_W+1  registered left speed.
REQ-015 rght_spd  output  FRWRD_W+1  registered right speed.
REQ-016 spd_vld  output  1  one-cycle pulse when the speed outputs update from a new sample.

Function
REQ-017 err_sat SHALL be error clamped to the signed SAT_W range: -2^(SAT_W-1) to 2^(SAT_W-1)-1.
REQ-018 P_term SHALL be err_sat*P_COEFF, signed, SAT_W+4 bits; the P contribution SHALL be P_term arithmetically shifted right by 1.
REQ-019 The integrator SHALL be signed SAT_W+5 bits; on err_vld&moving it SHALL load integrator+err_sat unless the signed add overflows, in which case it SHALL hold.
REQ-020 The I contribution SHALL be the pre-update integrator arithmetically shifted right by I_SHIFT.
REQ-021 A D_DEPTH-entry history SHALL shift in err_sat on each err_vld; D_diff SHALL be err_sat minus the oldest entry, clamped to signed 8 bits, times D_COEFF.
REQ-022 Stage 1: on err_vld, the P, I and D contributions and frwrd SHALL be registered, and an internal valid flag SHALL be set for one cycle.
REQ-023 Stage 2: PID SHALL be the sign-extended sum of the three contributions at SAT_W+4 bits, then arithmetically shifted right by 3.
REQ-024 Stage 2 SHALL set lft = frwrd+PID and rght = frwrd-PID, computed at signed FRWRD_W+3 bits and clamped to 0..2^FRWRD_W-1.
REQ-025 Latency: err_vld at edge N SHALL give updated outputs and spd_vld=1 after edge N+2; throughput is one sample per cycle.
REQ-026 Outputs SHALL hold between updates.
REQ-027 When moving=0: at the next edge, integrator, history and stage-1 valid SHALL clear; lft_spd and rght_spd SHALL load 0; spd_vld SHALL be 0; err_vld SHALL be ignored.
REQ-028 If moving falls while samples are in flight, those samples SHALL be discarded and SHALL NOT produce a spd_vld.

Reset
REQ-029 On rst_n low, all registers SHALL clear asynchronously: integrator, history, pipeline, lft_spd, rght_spd and spd_vld all 0.
REQ-030 Reset mid-operation SHALL discard in-flight samples; the first err_vld after release SHALL behave as a fresh start with a zero history.

Structure
REQ-031 The default parameter values and the derivative clamp width (8) SHALL live in the shared package pid_pkg.
REQ-032 A parametrised signed saturator sub-module, sat_signed (IN_W, OUT_W), SHALL be used for err_sat and D_diff.
REQ-033 Speed clamping SHALL stay inline in pid_pipe.

Verification
REQ-034 Defaults, moving=1, frwrd=0x100, single error=0x010 from reset -> two cycles later spd_vld=1, lft_spd=286, rght_spd=226.
REQ-035 From reset, single error=0x7FF, frwrd=0x300 -> lft_spd=1023 (clamped), rght_spd=146.
REQ-036 From reset, single error=0x800, frwrd=0x100 -> lft_spd=0 (clamped), rght_spd=880.
REQ-037 error=0x1FF with err_vld every cycle for 40 cycles -> integrator reaches 16352 after 32 samples and then holds (overflow freeze); the I contribution is 255.
REQ-038 moving dropped one cycle after an err_vld -> no spd_vld; outputs 0 and integrator 0 at the next edge; the first sample after moving rises again matches REQ-034.
REQ-039 rst_n asserted between err_vld and spd_vld -> outputs 0 immediately, no spd_vld; history and integrator are zero afterwards.

Source files
------------

// File: rtl/pid_pkg.sv
// rtl/pid_pkg.sv - shared defaults and fixed widths for the PID steering pipeline
package pid_pkg;

    localparam int DEF_ERR_W   = 12;
    localparam int DEF_SAT_W   = 10;
    localparam int DEF_FRWRD_W = 10;
    localparam int DEF_P_COEFF = 16;
    localparam int DEF_D_COEFF = 7;
    localparam int DEF_D_DEPTH = 3;
    localparam int DEF_I_SHIFT = 6;

    // Derivative difference is clamped to this signed width before the gain
    localparam int D_CLAMP_W   = 8;

endpackage

// File: rtl/sat_signed.sv
// rtl/sat_signed.sv - signed saturator from IN_W down to OUT_W bits
module sat_signed #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 10
) (
    input  logic signed [IN_W-1:0]  in_i,
    output logic signed [OUT_W-1:0] out_o
);

    localparam int HI_W = IN_W - OUT_W + 1;

    logic [HI_W-1:0] hi_bits;

    // In range when every bit from the output sign bit upward agrees
    always_comb begin
        hi_bits = in_i[IN_W-1:OUT_W-1];
        if (hi_bits == {HI_W{1'b0}} || hi_bits == {HI_W{1'b1}}) begin
            out_o = in_i[OUT_W-1:0];
        end else if (in_i[IN_W-1]) begin
            out_o = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            out_o = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/pid_pipe.sv
// rtl/pid_pipe.sv - two-stage PID heading controller producing left/right wheel speeds
module pid_pipe
    import pid_pkg::*;
#(
    parameter int ERR_W   = DEF_ERR_W,
    parameter int SAT_W   = DEF_SAT_W,
    parameter int FRWRD_W = DEF_FRWRD_W,
    parameter int P_COEFF = DEF_P_COEFF,
    parameter int D_COEFF = DEF_D_COEFF,
    parameter int D_DEPTH = DEF_D_DEPTH,
    parameter int I_SHIFT = DEF_I_SHIFT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    moving,
    input  logic                    err_vld,
    input  logic signed [ERR_W-1:0] error,
    input  logic [FRWRD_W-1:0]      frwrd,
    output logic [FRWRD_W:0]        lft_spd,
    output logic [FRWRD_W:0]        rght_spd,
    output logic                    spd_vld
);

    localparam int P_W = SAT_W + 4;      // width of P term and of the PID sum
    localparam int I_W = SAT_W + 5;      // integrator width
    localparam int S_W = FRWRD_W + 3;    // signed width for speed arithmetic

    localparam logic signed [P_W-1:0] P_K     = P_W'(P_COEFF);
    localparam logic signed [P_W-1:0] D_K     = P_W'(D_COEFF);
    localparam logic signed [S_W-1:0] SPD_MAX = S_W'((1 << FRWRD_W) - 1);

    logic signed [SAT_W-1:0]     err_sat;
    logic signed [P_W-1:0]       p_term;
    logic signed [P_W-1:0]       p_contrib;
    logic signed [I_W-1:0]       i_shr;
    logic signed [P_W-1:0]       i_contrib;
    logic signed [SAT_W:0]       d_raw;
    logic signed [D_CLAMP_W-1:0] d_sat;
    logic signed [P_W-1:0]       d_contrib;

    logic signed [I_W-1:0]       integ_q, integ_d;
    logic signed [I_W:0]         integ_sum;
    logic                        integ_ovf;
    logic signed [SAT_W-1:0]     hist_q [D_DEPTH];

    logic                        s1_vld_q;
    logic signed [P_W-1:0]       s1_p_q, s1_i_q, s1_d_q;
    logic [FRWRD_W-1:0]          s1_frwrd_q;

    logic signed [P_W-1:0]       pid_sum, pid;
    logic signed [S_W-1:0]       frwrd_ext, pid_ext, lft_raw, rght_raw;
    logic [FRWRD_W:0]            lft_d, rght_d;

    logic                        take;

    sat_signed #(.IN_W(ERR_W), .OUT_W(SAT_W)) u_err_sat (
        .in_i  (error),
        .out_o (err_sat)
    );

    sat_signed #(.IN_W(SAT_W + 1), .OUT_W(D_CLAMP_W)) u_d_sat (
        .in_i  (d_raw),
        .out_o (d_sat)
    );

    // P, I and D contributions for the incoming sample; I uses the pre-update integrator
    always_comb begin
        take      = moving & err_vld;
        p_term    = P_W'(err_sat) * P_K;
        p_contrib = p_term >>> 1;
        i_shr     = integ_q >>> I_SHIFT;
        i_contrib = P_W'(i_shr);
        d_raw     = (SAT_W + 1)'(err_sat) - (SAT_W + 1)'(hist_q[D_DEPTH-1]);
        d_contrib = P_W'(d_sat) * D_K;
        integ_sum = (I_W + 1)'(integ_q) + (I_W + 1)'(err_sat);
        integ_ovf = integ_sum[I_W] != integ_sum[I_W-1];
        integ_d   = integ_q;
        if (take && !integ_ovf) begin
            integ_d = integ_sum[I_W-1:0];
        end
    end

    // Integrator and error history; both are wiped whenever the robot stops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            integ_q <= '0;
            for (int k = 0; k < D_DEPTH; k++) hist_q[k] <= '0;
        end else if (!moving) begin
            integ_q <= '0;
            for (int k = 0; k < D_DEPTH; k++) hist_q[k] <= '0;
        end else begin
            integ_q <= integ_d;
            if (err_vld) begin
                hist_q[0] <= err_sat;
                for (int k = 1; k < D_DEPTH; k++) hist_q[k] <= hist_q[k-1];
            end
        end
    end

    // Stage 1 registers the three contributions and the forward speed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q   <= 1'b0;
            s1_p_q     <= '0;
            s1_i_q     <= '0;
            s1_d_q     <= '0;
            s1_frwrd_q <= '0;
        end else begin
            s1_vld_q <= take;
            if (take) begin
                s1_p_q     <= p_contrib;
                s1_i_q     <= i_contrib;
                s1_d_q     <= d_contrib;
                s1_frwrd_q <= frwrd;
            end
        end
    end

    // Stage 2 mixes PID into the forward speed and clamps each wheel to 0..max
    always_comb begin
        pid_sum   = s1_p_q + s1_i_q + s1_d_q;
        pid       = pid_sum >>> 3;
        frwrd_ext = S_W'(s1_frwrd_q);
        pid_ext   = S_W'(pid);
        lft_raw   = frwrd_ext + pid_ext;
        rght_raw  = frwrd_ext - pid_ext;
        lft_d     = lft_raw[FRWRD_W:0];
        rght_d    = rght_raw[FRWRD_W:0];
        if (lft_raw < 0)            lft_d  = '0;
        else if (lft_raw > SPD_MAX) lft_d  = SPD_MAX[FRWRD_W:0];
        if (rght_raw < 0)            rght_d = '0;
        else if (rght_raw > SPD_MAX) rght_d = SPD_MAX[FRWRD_W:0];
    end

    // Output registers hold between samples and drop to zero when stopped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lft_spd  <= '0;
            rght_spd <= '0;
            spd_vld  <= 1'b0;
        end else if (!moving) begin
            lft_spd  <= '0;
            rght_spd <= '0;
            spd_vld  <= 1'b0;
        end else begin
            spd_vld <= s1_vld_q;
            if (s1_vld_q) begin
                lft_spd  <= lft_d;
                rght_spd <= rght_d;
            end
        end
    end

endmodule

// File: tb/tb_pid_pipe.sv
// tb/tb_pid_pipe.sv - scoreboard bench for pid_pipe
module tb_pid_pipe;

    typedef struct {
        int lft;
        int rght;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        moving;
    logic        err_vld;
    logic [11:0] error;
    logic [9:0]  frwrd;
    logic [10:0] lft_spd;
    logic [10:0] rght_spd;
    logic        spd_vld;

    int   n_checks;
    int   n_fail;
    exp_t sb_q[$];
    exp_t mon_x;
    int   m_integ;
    int   m_hist[3];

    pid_pipe dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .moving   (moving),
        .err_vld  (err_vld),
        .error    (error),
        .frwrd    (frwrd),
        .lft_spd  (lft_spd),
        .rght_spd (rght_spd),
        .spd_vld  (spd_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic void model_clear();
        m_integ = 0;
        for (int k = 0; k < 3; k++) m_hist[k] = 0;
    endfunction

    function automatic exp_t model_step(input logic [11:0] e, input int fr);
        logic signed [11:0] se;
        int   es, p, i, d, pid, nxt;
        exp_t r;
        se  = e;
        es  = clampi(int'(se), -512, 511);
        p   = (es * 16) >>> 1;
        i   = m_integ >>> 6;
        d   = clampi(es - m_hist[2], -128, 127) * 7;
        pid = (p + i + d) >>> 3;
        r.lft  = clampi(fr + pid, 0, 1023);
        r.rght = clampi(fr - pid, 0, 1023);
        nxt = m_integ + es;
        if (nxt >= -16384 && nxt <= 16383) m_integ = nxt;
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = es;
        return r;
    endfunction

    task automatic cyc(input bit vld, input logic [11:0] e, input logic [9:0] fr);
        @(posedge clk);
        #1;
        err_vld = vld;
        error   = e;
        frwrd   = fr;
        if (vld && moving) sb_q.push_back(model_step(e, int'(fr)));
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        moving  = 1'b1;
        err_vld = 1'b0;
        error   = '0;
        frwrd   = '0;
        sb_q.delete();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic directed(input string tag, input logic [11:0] e, input logic [9:0] fr,
                            input int el, input int er);
        do_reset();
        cyc(1'b1, e, fr);
        cyc(1'b0, '0, '0);
        @(posedge clk);
        #1;
        check({tag, "_vld"}, spd_vld, 1);
        check({tag, "_lft"}, lft_spd, el);
        check({tag, "_rght"}, rght_spd, er);
    endtask

    // Every spd_vld pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (spd_vld === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_spd_vld", 1, 0);
            end else begin
                mon_x = sb_q.pop_front();
                check("sb_lft", lft_spd, mon_x.lft);
                check("sb_rght", rght_spd, mon_x.rght);
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        moving   = 1'b0;
        err_vld  = 1'b0;
        error    = '0;
        frwrd    = '0;
        model_clear();
        #23;
        check("rst_lft", lft_spd, 0);
        check("rst_rght", rght_spd, 0);
        check("rst_vld", spd_vld, 0);
        check("rst_integ", dut.integ_q, 0);

        directed("basic", 12'h010, 10'h100, 286, 226);
        directed("pos_clamp", 12'h7FF, 10'h300, 1023, 146);
        directed("neg_clamp", 12'h800, 10'h100, 0, 880);

        // Integrator saturation with a sustained positive error
        do_reset();
        for (int n = 1; n <= 40; n++) begin
            cyc(1'b1, 12'h1FF, 10'h200);
            if (n == 33) check("integ_after_32", dut.integ_q, 16352);
        end
        cyc(1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        check("integ_frozen", dut.integ_q, 16352);
        check("i_contrib", dut.s1_i_q, 255);
        check("integ_model", m_integ, 16352);

        // Random traffic with gaps
        do_reset();
        for (int n = 0; n < 120; n++) begin
            cyc($urandom_range(0, 3) != 0, 12'($urandom_range(0, 4095)),
                10'($urandom_range(0, 1023)));
        end
        repeat (3) cyc(1'b0, '0, '0);
        check("rand_drained", sb_q.size(), 0);

        // moving falls while a sample sits in stage 1
        do_reset();
        cyc(1'b1, 12'h010, 10'h100);
        cyc(1'b0, '0, '0);
        repeat (2) @(posedge clk);
        cyc(1'b1, 12'h040, 10'h080);
        @(posedge clk);
        #1;
        moving  = 1'b0;
        err_vld = 1'b0;
        sb_q.delete();
        model_clear();
        @(posedge clk);
        #1;
        check("stop_vld", spd_vld, 0);
        check("stop_lft", lft_spd, 0);
        check("stop_rght", rght_spd, 0);
        check("stop_integ", dut.integ_q, 0);
        @(posedge clk);
        #1;
        check("stop_still_no_vld", spd_vld, 0);
        moving = 1'b1;
        cyc(1'b1, 12'h010, 10'h100);
        cyc(1'b0, '0, '0);
        @(posedge clk);
        #1;
        check("restart_vld", spd_vld, 1);
        check("restart_lft", lft_spd, 286);
        check("restart_rght", rght_spd, 226);

        // Asynchronous reset with a sample in flight
        do_reset();
        cyc(1'b1, 12'h010, 10'h100);
        cyc(1'b0, '0, '0);
        repeat (2) @(posedge clk);
        cyc(1'b1, 12'h100, 10'h300);
        @(posedge clk);
        #1;
        err_vld = 1'b0;
        rst_n   = 1'b0;
        #1;
        check("arst_lft", lft_spd, 0);
        check("arst_rght", rght_spd, 0);
        check("arst_vld", spd_vld, 0);
        check("arst_integ", dut.integ_q, 0);
        check("arst_hist0", dut.hist_q[0], 0);
        check("arst_hist1", dut.hist_q[1], 0);
        check("arst_hist2", dut.hist_q[2], 0);
        sb_q.delete();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("arst_no_vld", spd_vld, 0);
        cyc(1'b1, 12'h010, 10'h100);
        cyc(1'b0, '0, '0);
        @(posedge clk);
        #1;
        check("fresh_vld", spd_vld, 1);
        check("fresh_lft", lft_spd, 286);
        check("fresh_rght", rght_spd, 226);

        repeat (2) @(posedge clk);
        check("final_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
